// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the IF stage
// (fetch, read-only) and the MEM stage (load/store). Each transaction walks
// IDLE -> ISSUE -> WAIT -> RESP. MEM-stage requests win arbitration, but a
// streak counter forces a fetch grant after MAX_DSTREAK back-to-back data
// grants while a fetch is pending, so the front end cannot starve.
//
// Handshake: a requester raises req with stable attributes and holds it until
// it sees a one-cycle ack. Attributes are captured at grant, so later changes
// are ignored. In the cycle after ack the arbiter is back in IDLE and samples
// whatever requests are present then.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LATENCY     = 2,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    // data port
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_stall,
    // backing memory
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              busy,
    output logic              owner,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int STR_W = $clog2(MAX_DSTREAK + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LATENCY - 1);
    localparam logic [STR_W-1:0] STREAK_MAX = STR_W'(MAX_DSTREAK);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 0 = IF, 1 = DM
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STR_W-1:0]  streak_q, streak_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic grant_dm;
    logic grant_if;

    // Data wins unless a fetch is waiting and the data streak is exhausted.
    assign grant_dm = dm_req && (!if_req || (streak_q < STREAK_MAX));
    assign grant_if = if_req && !grant_dm;

    // State and latch registers; reset abandons any transaction in flight.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            streak_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Next-state logic: arbitration in IDLE, latency count in WAIT.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (grant_dm) begin
                    owner_d = 1'b1;
                    we_d    = dm_we;
                    addr_d  = dm_addr;
                    wdata_d = dm_wdata;
                    state_d = S_ISSUE;
                    // Only data grants that bypass a waiting fetch extend the streak.
                    if (if_req) begin
                        if (streak_q < STREAK_MAX) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        streak_d = '0;
                    end
                end else if (grant_if) begin
                    owner_d  = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = if_addr;
                    state_d  = S_ISSUE;
                    streak_d = '0;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: strobes come straight from the state, data from latches.
    always_comb begin
        mem_en    = (state_q == S_ISSUE);
        mem_we    = (state_q == S_ISSUE) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_ack    = (state_q == S_RESP) && !owner_q;
        dm_ack    = (state_q == S_RESP) && owner_q;
        if_stall  = if_req && !if_ack;
        dm_stall  = dm_req && !dm_ack;
        if_rdata  = if_rdata_q;
        dm_rdata  = dm_rdata_q;
        busy      = (state_q != S_IDLE);
        owner     = owner_q;
        dbg_state = state_q;
    end

endmodule
